mutative_predictor: RTL and testbench

- Upstream policy stage for the mutative cache controller.
- Counts hits and misses over fixed-length epochs of cache accesses.
- Runs a hill-climbing policy on successive epoch miss counts and issues single-step associativity-mutation requests (setup_valid/setup_update) to the flush/setup controller.
- Mirrors the controller's 0..3 setup level locally.

---
 rtl/mutative_predictor.sv | 168 ++++++++++++++++
 tb/tb_mutative_predictor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mutative_predictor.sv
// mutative_predictor: epoch-based hill-climbing policy stage for the mutative
// cache controller. It counts hits and misses over fixed-length epochs and
// compares successive epoch miss counts. From that comparison it issues
// single-step associativity-mutation requests, and it mirrors the
// controller's 0..3 setup level.
// Optional build macro: MUTATIVE_PREDICTOR_PERF_EN adds perf_epochs and
// perf_requests counter outputs.
module mutative_predictor #(
    parameter int EPOCH_LEN = 64,
    parameter int HYST      = 2,
    parameter int COOLDOWN  = 16,
    parameter int MISS_W    = $clog2(EPOCH_LEN) + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       access_valid,
    input  logic       access_hit,
    input  logic       flush_stall,
    output logic       setup_valid,
    output logic       setup_update,
    input  logic       setup_ready,
    output logic [1:0] level
`ifdef MUTATIVE_PREDICTOR_PERF_EN
    ,
    output logic [31:0] perf_epochs,
    output logic [31:0] perf_requests
`endif
);

    localparam int ACC_W  = $clog2(EPOCH_LEN);
    localparam int COOL_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [MISS_W:0]   HYST_W   = (MISS_W + 1)'(HYST);
    localparam logic [MISS_W-1:0] MISS_MAX = {MISS_W{1'b1}};

    typedef enum logic [1:0] {
        P_COUNT,
        P_DECIDE,
        P_REQ,
        P_COOLDOWN
    } state_t;

    state_t            state;
    logic [ACC_W-1:0]  acc_cnt;
    logic [MISS_W-1:0] miss_cnt;
    logic [MISS_W-1:0] cur_miss;
    logic [MISS_W-1:0] prev_miss;
    logic              prev_valid;
    logic              dir;
    logic [COOL_W-1:0] cool_cnt;

    logic [MISS_W-1:0] miss_next;
    logic [MISS_W:0]   cur_w;
    logic [MISS_W:0]   prev_w;
    logic              next_dir;
    logic              req;
    logic              counted;

    assign counted      = access_valid && !flush_stall;
    assign setup_update = dir;

    // Saturating miss count including the current access.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        miss_next = miss_cnt;
        if (!access_hit && miss_cnt != MISS_MAX)
            miss_next = miss_cnt + MISS_W'(1);
    end

    // Hill-climbing decision: keep climbing while misses improve, reverse when
    // they worsen beyond the hysteresis band, and never step past level 0/3.
    always_comb begin
        cur_w    = {1'b0, cur_miss};
        prev_w   = {1'b0, prev_miss};
        next_dir = dir;
        req      = 1'b0;
        if (!prev_valid) begin
            req = 1'b1;
        end else if (cur_w > prev_w + HYST_W) begin
            next_dir = ~dir;
            req      = 1'b1;
        end else if (cur_w + HYST_W < prev_w) begin
            req = 1'b1;
        end
        if (req && ((next_dir && level == 2'd3) || (!next_dir && level == 2'd0))) begin
            req      = 1'b0;
            next_dir = ~next_dir;
        end
    end

    // Policy FSM with its counters, direction, level mirror and registered request.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= P_COUNT;
            acc_cnt     <= '0;
            miss_cnt    <= '0;
            cur_miss    <= '0;
            prev_miss   <= '0;
            prev_valid  <= 1'b0;
            dir         <= 1'b1;
            level       <= 2'd0;
            cool_cnt    <= '0;
            setup_valid <= 1'b0;
        end else begin
            case (state)
                P_COUNT: begin
                    if (counted) begin
                        if (acc_cnt == ACC_W'(EPOCH_LEN - 1)) begin
                            cur_miss <= miss_next;
                            acc_cnt  <= '0;
                            miss_cnt <= '0;
                            state    <= P_DECIDE;
                        end else begin
                            acc_cnt  <= acc_cnt + ACC_W'(1);
                            miss_cnt <= miss_next;
                        end
                    end
                end
                P_DECIDE: begin
                    prev_miss  <= cur_miss;
                    prev_valid <= 1'b1;
                    dir        <= next_dir;
                    if (req) begin
                        state       <= P_REQ;
                        setup_valid <= 1'b1;
                    end else begin
                        state <= P_COUNT;
                    end
                end
                P_REQ: begin
                    if (setup_ready) begin
                        level       <= dir ? level + 2'd1 : level - 2'd1;
                        cool_cnt    <= COOL_W'(COOLDOWN - 1);
                        setup_valid <= 1'b0;
                        state       <= P_COOLDOWN;
                    end
                end
                P_COOLDOWN: begin
                    if (cool_cnt == '0)
                        state <= P_COUNT;
                    else
                        cool_cnt <= cool_cnt - COOL_W'(1);
                end
                default: begin
                    state       <= P_COUNT;
                    setup_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MUTATIVE_PREDICTOR_PERF_EN
    // Free-running epoch and accepted-request counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_epochs   <= '0;
            perf_requests <= '0;
        end else begin
            if (state == P_DECIDE)
                perf_epochs <= perf_epochs + 32'd1;
            if (state == P_REQ && setup_ready)
                perf_requests <= perf_requests + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mutative_predictor.sv
// tb_mutative_predictor: randomized scoreboard bench for mutative_predictor
// (EPOCH_LEN=16, HYST=2, COOLDOWN=8). The driver builds epochs with a chosen
// miss count. A behavioural policy model queues each expected request, and a
// monitor checks every handshake the DUT presents.
module tb_mutative_predictor;

    localparam int EPOCH_LEN = 16;
    localparam int HYST      = 2;
    localparam int COOLDOWN  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       access_valid;
    logic       access_hit;
    logic       flush_stall;
    logic       setup_valid;
    logic       setup_update;
    logic       setup_ready;
    logic [1:0] level;
`ifdef MUTATIVE_PREDICTOR_PERF_EN
    logic [31:0] perf_epochs;
    logic [31:0] perf_requests;
`endif

    mutative_predictor #(
        .EPOCH_LEN(EPOCH_LEN),
        .HYST     (HYST),
        .COOLDOWN (COOLDOWN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .access_valid (access_valid),
        .access_hit   (access_hit),
        .flush_stall  (flush_stall),
        .setup_valid  (setup_valid),
        .setup_update (setup_update),
        .setup_ready  (setup_ready),
        .level        (level)
`ifdef MUTATIVE_PREDICTOR_PERF_EN
        ,
        .perf_epochs  (perf_epochs),
        .perf_requests(perf_requests)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       upd;
        bit [1:0] lvl_after;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Policy model state, expressed as plain integers.
    int m_level, m_dir, m_prev, m_prev_valid;
    int m_epochs, m_reqs;

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_level = 0; m_dir = 1; m_prev = 0; m_prev_valid = 0;
        m_epochs = 0; m_reqs = 0;
    endtask

    // Apply inputs for one cycle; they are sampled by the following posedge.
    task automatic step(input bit v, input bit h, input bit s, input bit r);
        access_valid = v; access_hit = h; flush_stall = s; setup_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic junk_step(input bit r);
        step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), r);
    endtask

    // Epoch decision from the hill-climbing rules; returns 1 if a request is due.
    function automatic bit model_decide(input int cur);
        bit r;
        int nd;
        nd = m_dir;
        r  = 0;
        if (m_prev_valid == 0) r = 1;
        else if (cur > m_prev + HYST) begin nd = 1 - m_dir; r = 1; end
        else if (cur + HYST < m_prev) r = 1;
        if (r && ((nd == 1 && m_level == 3) || (nd == 0 && m_level == 0))) begin
            r  = 0;
            nd = 1 - nd;
        end
        m_prev = cur; m_prev_valid = 1; m_dir = nd; m_epochs++;
        return r;
    endfunction

    // One full epoch with exactly 'misses' counted misses, then the decision,
    // the optional handshake (with random back-pressure) and the cooldown.
    task automatic run_epoch(input int misses);
        int   cnt, ml, k;
        bit   v, s, h, req;
        exp_t e;
        check("level_at_epoch_start", level, m_level);
        cnt = 0;
        ml  = misses;
        while (cnt < EPOCH_LEN) begin
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 4) == 0);
            h = $urandom_range(0, 1);
            if (v && !s) begin
                h = !($urandom_range(1, EPOCH_LEN - cnt) <= ml);
                if (!h) ml--;
                cnt++;
            end
            step(v, h, s, $urandom_range(0, 1));
        end
        req = model_decide(misses);
        if (req) begin
            e.upd       = m_dir[0];
            e.lvl_after = 2'((m_dir == 1) ? m_level + 1 : m_level - 1);
            q.push_back(e);
            m_level = e.lvl_after;
            m_reqs++;
        end
        junk_step($urandom_range(0, 1));       // decide cycle
        check("setup_valid_after_decide", setup_valid, req);
        check("setup_update_is_dir", setup_update, m_dir);
        if (req) begin
            k = $urandom_range(0, 10);
            for (int i = 0; i < k; i++) begin
                junk_step(1'b0);
                check("setup_valid_held", setup_valid, 1);
                check("setup_update_held", setup_update, m_dir);
            end
            junk_step(1'b1);                    // transfer
            for (int i = 0; i < COOLDOWN; i++) begin
                junk_step($urandom_range(0, 1));
                if (i == 0) check("setup_valid_in_cooldown", setup_valid, 0);
            end
        end
    endtask

    // Monitor: pops an expectation at each handshake, then checks the
    // level update and request release one cycle later.
    bit       pend = 0;
    bit [1:0] pend_lvl;
    always @(negedge clk) begin
        exp_t e;
        if (pend) begin
            check("level_after_transfer", level, pend_lvl);
            check("setup_valid_dropped", setup_valid, 0);
            pend = 0;
        end
        if (!rst && setup_valid && setup_ready) begin
            if (q.size() == 0) begin
                check("unexpected_request", 1, 0);
            end else begin
                e = q.pop_front();
                check("transfer_update", setup_update, e.upd);
                pend     = 1;
                pend_lvl = e.lvl_after;
            end
        end
    end

    int directed[$] = '{5, 10, 6, 10, 3, 0, 0, 16, 16, 1};

    initial begin
        rst = 1'b1;
        access_valid = 0; access_hit = 0; flush_stall = 0; setup_ready = 0;
        model_reset();
        @(posedge clk); #1;
        step(1, 0, 0, 1);
        check("reset_setup_valid", setup_valid, 0);
        check("reset_setup_update", setup_update, 1);
        check("reset_level", level, 0);
        rst = 1'b0;

        // A long stall burst must not advance the epoch.
        for (int i = 0; i < 20; i++) step(1, 0, 1, 0);

        foreach (directed[i]) run_epoch(directed[i]);
        for (int i = 0; i < 30; i++) run_epoch($urandom_range(0, EPOCH_LEN));
        step(0, 0, 0, 0);
        check("queue_drained", q.size(), 0);
`ifdef MUTATIVE_PREDICTOR_PERF_EN
        check("perf_epochs", perf_epochs, m_epochs);
        check("perf_requests", perf_requests, m_reqs);
`endif

        // Reset in the middle of a pending request drops it.
        rst = 1'b1;
        step(0, 0, 0, 0);
        rst = 1'b0;
        model_reset();
        q.delete();
        for (int i = 0; i < EPOCH_LEN; i++) step(1, (i % 3) != 0, 0, 0);
        step(0, 0, 0, 0);                       // decide cycle
        check("first_epoch_request", setup_valid, 1);
        step(1, 0, 0, 0);
        rst = 1'b1;
        step(1, 0, 0, 0);
        check("rst_in_req_valid", setup_valid, 0);
        check("rst_in_req_level", level, 0);
        check("rst_in_req_update", setup_update, 1);
        rst = 1'b0;
        model_reset();
        run_epoch(8);
        step(0, 0, 0, 0);
        check("queue_drained_final", q.size(), 0);
        check("final_level", level, m_level);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
